// File: rtl/wait_state_memory.sv
// Single-port synchronous data memory with a valid/ready request channel,
// configurable wait states, a one-cycle response pulse and out-of-range reporting.
module wait_state_memory #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0]      WS_INIT   = 8'(WAIT_STATES);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept;
    logic              enter_done;
    logic              op_from_reg;
    logic [ADDR_W-1:0] op_addr;
    logic              op_write;
    logic [DATA_W-1:0] op_wdata;
    logic              op_in_range;

    function automatic logic [DATA_W-1:0] init_word(input int idx);
        if (idx == 0) return DATA_W'(1);
        if (idx == 1) return DATA_W'(2);
        return '0;
    endfunction

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_LIM);
    endfunction

    assign req_ready  = (state_q != S_WAIT);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Zero-wait accesses complete on the accept edge itself, so the operands
    // come straight from the request port; otherwise from the captured copy.
    assign op_from_reg = (state_q == S_WAIT);
    assign op_addr     = op_from_reg ? addr_q  : req_addr;
    assign op_write    = op_from_reg ? write_q : req_write;
    assign op_wdata    = op_from_reg ? wdata_q : req_wdata;
    assign op_in_range = addr_in_range(op_addr);
    assign enter_done  = (state_d == S_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 8'd1) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (enter_done) begin
            err_d   = !op_in_range;
            rdata_d = (op_in_range && !op_write) ? mem_q[op_addr] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request operands are pure data and need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            write_q <= req_write;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= init_word(i);
            end
        end else if (enter_done && op_write && op_in_range) begin
            mem_q[op_addr] <= op_wdata;
        end
    end

endmodule

// File: tb/tb_wait_state_memory.sv
// Bench for wait_state_memory: four instances with different latency/depth,
// directed scenarios plus a randomized run against an array-based model.
module tb_wait_state_memory;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       rv   [4];
    logic       rw   [4];
    logic       rr   [4];
    logic       vld  [4];
    logic       er   [4];
    logic       bsy  [4];
    logic [3:0] ra   [4];
    logic [7:0] rd   [4];
    logic [7:0] rdat [4];
    logic [7:0] mdl  [4][16];
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    wait_state_memory #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .WAIT_STATES(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rr[0]), .req_write(rw[0]),
        .req_addr(ra[0]), .req_wdata(rd[0]), .resp_valid(vld[0]), .resp_rdata(rdat[0]),
        .resp_err(er[0]), .busy(bsy[0]));
    wait_state_memory #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .WAIT_STATES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rr[1]), .req_write(rw[1]),
        .req_addr(ra[1]), .req_wdata(rd[1]), .resp_valid(vld[1]), .resp_rdata(rdat[1]),
        .resp_err(er[1]), .busy(bsy[1]));
    wait_state_memory #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .WAIT_STATES(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[2]), .req_ready(rr[2]), .req_write(rw[2]),
        .req_addr(ra[2]), .req_wdata(rd[2]), .resp_valid(vld[2]), .resp_rdata(rdat[2]),
        .resp_err(er[2]), .busy(bsy[2]));
    wait_state_memory #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .WAIT_STATES(2)) dut_d (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[3]), .req_ready(rr[3]), .req_write(rw[3]),
        .req_addr(ra[3]), .req_wdata(rd[3]), .resp_valid(vld[3]), .resp_rdata(rdat[3]),
        .resp_err(er[3]), .busy(bsy[3]));

    function automatic int ws_of(input int k);
        case (k)
            1:       return 3;
            3:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int depth_of(input int k);
        return (k == 2) ? 12 : 16;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++) mdl[k][i] = 8'h00;
            mdl[k][0] = 8'h01;
            mdl[k][1] = 8'h02;
        end
    endtask

    // Behavioural memory: in-range writes land, reads return stored words,
    // anything past the implemented depth reports an error and returns zero.
    function automatic void model_access(input int k, input bit wr, input logic [3:0] a,
                                         input logic [7:0] d, output logic [7:0] rdx,
                                         output bit erx);
        if (int'(a) >= depth_of(k)) begin
            rdx = 8'h00;
            erx = 1'b1;
        end else if (wr) begin
            mdl[k][a] = d;
            rdx = 8'h00;
            erx = 1'b0;
        end else begin
            rdx = mdl[k][a];
            erx = 1'b0;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Present a request and hold it until the accepting edge; returns at edge+1.
    task automatic issue(input int k, input bit wr, input logic [3:0] a, input logic [7:0] d,
                         input string tag);
        int guard;
        @(negedge clk);
        rv[k] = 1'b1;
        rw[k] = wr;
        ra[k] = a;
        rd[k] = d;
        guard = 0;
        while (rr[k] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk({tag, " ready timeout"}, rr[k], 1);
        @(posedge clk);
        #1;
        rv[k] = 1'b0;
    endtask

    task automatic wait_resp(input int k, output int lat);
        lat = 1;
        while (vld[k] !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic access(input int k, input bit wr, input logic [3:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd, input bit exp_er, input string tag);
        int lat;
        issue(k, wr, a, d, tag);
        wait_resp(k, lat);
        chk({tag, " latency"}, lat, ws_of(k) + 1);
        chk({tag, " rdata"}, rdat[k], exp_rd);
        chk({tag, " err"}, er[k], exp_er);
        @(posedge clk);
        #1;
        chk({tag, " pulse width"}, vld[k], 0);
    endtask

    initial begin
        int         pulses;
        int         lat;
        bit         wr;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] exp_rd;
        bit         exp_er;

        for (int k = 0; k < 4; k++) begin
            rv[k] = 1'b0; rw[k] = 1'b0; ra[k] = 4'h0; rd[k] = 8'h00;
        end
        #2 rst_n = 1'b0;
        #10;
        for (int k = 0; k < 4; k++) begin
            chk("reset resp_valid", vld[k], 0);
            chk("reset busy", bsy[k], 0);
            chk("reset rdata", rdat[k], 0);
            chk("reset err", er[k], 0);
            chk("reset ready", rr[k], 1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Zero-wait reads of the reset contents
        access(0, 1'b0, 4'd0, 8'h00, 8'h01, 1'b0, "t1 read0");
        access(0, 1'b0, 4'd1, 8'h00, 8'h02, 1'b0, "t1 read1");
        access(0, 1'b0, 4'd5, 8'h00, 8'h00, 1'b0, "t1 read5");

        // Write then read presented in the DONE cycle
        @(negedge clk);
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 4'd7; rd[0] = 8'hA5;
        chk("t2 ready idle", rr[0], 1);
        @(posedge clk);
        #1;
        chk("t2 write resp", vld[0], 1);
        chk("t2 write rdata", rdat[0], 8'h00);
        chk("t2 write err", er[0], 0);
        rw[0] = 1'b0; rd[0] = 8'h00;
        chk("t2 ready in done", rr[0], 1);
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        chk("t2 read resp", vld[0], 1);
        chk("t2 read rdata", rdat[0], 8'hA5);
        chk("t2 read err", er[0], 0);
        @(posedge clk);
        #1;
        chk("t2 back to idle valid", vld[0], 0);
        chk("t2 back to idle busy", bsy[0], 0);

        // Three wait states, with a second request held during WAIT
        @(negedge clk);
        rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 4'd1; rd[1] = 8'h00;
        chk("t3 ready idle", rr[1], 1);
        @(posedge clk);
        #1;
        ra[1] = 4'd0;
        for (int i = 0; i < 3; i++) begin
            chk("t3 wait ready", rr[1], 0);
            chk("t3 wait busy", bsy[1], 1);
            chk("t3 wait no resp", vld[1], 0);
            @(posedge clk);
            #1;
        end
        chk("t3 resp valid", vld[1], 1);
        chk("t3 resp rdata", rdat[1], 8'h02);
        chk("t3 resp err", er[1], 0);
        chk("t3 ready in done", rr[1], 1);
        @(posedge clk);
        #1;
        rv[1] = 1'b0;
        chk("t3 held req accepted", bsy[1], 1);
        chk("t3 held req waiting", vld[1], 0);
        wait_resp(1, lat);
        chk("t3 held latency", lat, 4);
        chk("t3 held rdata", rdat[1], 8'h01);

        // Depth 12: out-of-range accesses
        access(2, 1'b1, 4'd13, 8'h55, 8'h00, 1'b1, "t4 write13");
        access(2, 1'b0, 4'd13, 8'h00, 8'h00, 1'b1, "t4 read13");
        access(2, 1'b0, 4'd11, 8'h00, 8'h00, 1'b0, "t4 read11");
        access(2, 1'b0, 4'd0, 8'h00, 8'h01, 1'b0, "t4 read0");

        // Reset in the middle of a waiting write
        do_reset();
        issue(1, 1'b1, 4'd0, 8'hFF, "t5 write");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5 reset busy", bsy[1], 0);
        chk("t5 reset valid", vld[1], 0);
        chk("t5 reset ready", rr[1], 1);
        pulses = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (6) begin
            @(posedge clk);
            #1;
            if (vld[1] === 1'b1) pulses++;
        end
        chk("t5 no aborted resp", pulses, 0);
        chk("t5 idle after abort", bsy[1], 0);
        access(1, 1'b0, 4'd0, 8'h00, 8'h01, 1'b0, "t5 read0");

        // Randomized traffic against the model, two wait states
        do_reset();
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            d  = 8'($urandom);
            model_access(3, wr, a, d, exp_rd, exp_er);
            access(3, wr, a, d, exp_rd, exp_er, wr ? "t6 rand write" : "t6 rand read");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
